// File: rtl/secded_pkg.sv
// secded_pkg: SEC-DED column codes, check-width derivation and out_err encodings
package secded_pkg;
  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_DATA   = 2'b01;
  localparam logic [1:0] ERR_CHK    = 2'b10;
  localparam logic [1:0] ERR_UNCORR = 2'b11;
  function automatic int secded_pw(input int dw);
    return $clog2(1 + dw + $clog2(1 + dw)) + 1;
  endfunction
  function automatic int secded_col(input int i, input int pw);
    int n;
    int low;
    n = i + 1;
    low = n + $clog2(1 + n + $clog2(1 + n));
    low = low & ((1 << (pw - 1)) - 1);
    return low | (int'(~^low) << (pw - 1));
  endfunction
endpackage

// File: rtl/secded_chk_gen.sv
// secded_chk_gen: combinational check-bit generator (i_data DW in, o_chk PW out)
module secded_chk_gen
  import secded_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = secded_pw(DW)
) (
  input  logic [DW-1:0] i_data,
  output logic [PW-1:0] o_chk
);
  logic [PW-1:0] w_col [DW];
  for (genvar i = 0; i < DW; i++) begin : g_col
    assign w_col[i] = PW'(secded_col(i, PW));
  end
  always_comb begin
    o_chk = '0;
    for (int k = 0; k < DW; k++) o_chk = o_chk ^ ({PW{i_data[k]}} & w_col[k]);
  end
endmodule

// File: rtl/secded_dec_pipe.sv
// secded_dec_pipe: 2-stage SEC-DED decoder; in_* / out_* valid-ready streams, clr_cnt + saturating cnt_corr/cnt_uncorr, sticky irq_uncorr; SECDED_ERR_LOG_EN adds log_valid/log_tag/log_syn
module secded_dec_pipe
  import secded_pkg::*;
#(
  parameter int DW    = 32,
  parameter int PW    = secded_pw(DW),
  parameter int TW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [PW-1:0]    in_check,
  input  logic [TW-1:0]    in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [TW-1:0]    out_tag,
  output logic [1:0]       out_err,
  output logic [PW-1:0]    out_syn,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr,
  output logic             irq_uncorr
`ifdef SECDED_ERR_LOG_EN
  ,
  output logic             log_valid,
  output logic [TW-1:0]    log_tag,
  output logic [PW-1:0]    log_syn
`endif
);
  logic [PW-1:0] w_chk;
  logic [PW-1:0] w_col [DW];
  logic [DW-1:0] w_flip;
  logic [1:0] w_err;
  logic w_s1_en, w_s2_en, w_hs, w_corr, w_uncorr;
  logic r_s1_vld, r_s2_vld, r_irq;
  logic [DW-1:0] r_s1_data, r_s2_data;
  logic [PW-1:0] r_s1_syn, r_s2_syn;
  logic [TW-1:0] r_s1_tag, r_s2_tag;
  logic [1:0] r_s2_err;
  logic [CNT_W-1:0] r_cnt_corr, r_cnt_uncorr;
  secded_chk_gen #(.DW(DW), .PW(PW)) u_chk (.i_data(in_data), .o_chk(w_chk));
  for (genvar i = 0; i < DW; i++) begin : g_match
    assign w_col[i]  = PW'(secded_col(i, PW));
    assign w_flip[i] = r_s1_syn == w_col[i];
  end
  assign w_err = ~|r_s1_syn ? ERR_NONE : |w_flip ? ERR_DATA : $onehot(r_s1_syn) ? ERR_CHK : ERR_UNCORR;
  assign w_s2_en  = ~r_s2_vld | out_ready;
  assign w_s1_en  = ~r_s1_vld | w_s2_en;
  assign in_ready = w_s1_en;
  assign w_hs     = r_s2_vld & out_ready;
  assign w_corr   = w_hs & (r_s2_err == ERR_DATA || r_s2_err == ERR_CHK);
  assign w_uncorr = w_hs & (r_s2_err == ERR_UNCORR);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_syn  <= '0;
      r_s1_tag  <= '0;
    end else if (w_s1_en) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_syn  <= w_chk ^ in_check;
        r_s1_tag  <= in_tag;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_err  <= ERR_NONE;
      r_s2_syn  <= '0;
      r_s2_tag  <= '0;
    end else if (w_s2_en) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= r_s1_data ^ w_flip;
        r_s2_err  <= w_err;
        r_s2_syn  <= r_s1_syn;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
      r_irq        <= 1'b0;
    end else if (clr_cnt) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (w_corr && !(&r_cnt_corr)) r_cnt_corr <= r_cnt_corr + 1'b1;
      if (w_uncorr && !(&r_cnt_uncorr)) r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
      if (w_uncorr) r_irq <= 1'b1;
    end
  end
`ifdef SECDED_ERR_LOG_EN
  logic r_log_vld;
  logic [TW-1:0] r_log_tag;
  logic [PW-1:0] r_log_syn;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr_cnt) begin
      r_log_vld <= 1'b0;
      r_log_tag <= '0;
      r_log_syn <= '0;
    end else if (w_uncorr && !r_log_vld) begin
      r_log_vld <= 1'b1;
      r_log_tag <= r_s2_tag;
      r_log_syn <= r_s2_syn;
    end
  end
  assign log_valid = r_log_vld;
  assign log_tag   = r_log_tag;
  assign log_syn   = r_log_syn;
`endif
  assign out_valid  = r_s2_vld;
  assign out_data   = r_s2_data;
  assign out_err    = r_s2_err;
  assign out_syn    = r_s2_syn;
  assign out_tag    = r_s2_tag;
  assign cnt_corr   = r_cnt_corr;
  assign cnt_uncorr = r_cnt_uncorr;
  assign irq_uncorr = r_irq;
endmodule

// File: tb/tb_secded_dec_pipe.sv
// tb_secded_dec_pipe: directed + random bench for secded_dec_pipe against a Hamming-position reference model
module tb_secded_dec_pipe;
  localparam int DW = 32, PW = 7, TW = 4, CW = 4, CMAX = 15;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, clr_cnt = 0, irq_uncorr;
  logic [DW-1:0] in_data = 0, out_data;
  logic [PW-1:0] in_check = 0, out_syn;
  logic [TW-1:0] in_tag = 0, out_tag;
  logic [1:0] out_err;
  logic [CW-1:0] cnt_corr, cnt_uncorr;
`ifdef SECDED_ERR_LOG_EN
  logic log_valid;
  logic [TW-1:0] log_tag;
  logic [PW-1:0] log_syn;
`endif
  always #5 clk = ~clk;
  secded_dec_pipe #(.DW(DW), .TW(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_check(in_check), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err), .out_syn(out_syn),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr), .irq_uncorr(irq_uncorr)
`ifdef SECDED_ERR_LOG_EN
    , .log_valid(log_valid), .log_tag(log_tag), .log_syn(log_syn)
`endif
  );
  typedef struct {
    logic [DW-1:0] d;
    logic [1:0] e;
    logic [PW-1:0] s;
    logic [TW-1:0] t;
    int a;
  } item_t;
  item_t q[$];
  int n_tests = 0, n_fail = 0, cyc_n = 0, last_pop = -100;
  int m_corr = 0, m_uncorr = 0;
  bit m_irq = 0, m_lv = 0;
  logic [TW-1:0] m_lt = 0;
  logic [PW-1:0] m_ls = 0;
  bit acc;
  function automatic logic [PW-1:0] col_of(input int i);
    int p, idx;
    logic [5:0] l;
    p = 2;
    idx = -1;
    while (idx < i) begin
      p++;
      if ((p & (p - 1)) != 0) idx++;
    end
    l = p[5:0];
    return {~^l, l};
  endfunction
  function automatic void ref_dec(input logic [DW-1:0] d, input logic [PW-1:0] c,
                                  output logic [DW-1:0] od, output logic [1:0] e, output logic [PW-1:0] s);
    logic [PW-1:0] k;
    k = '0;
    for (int i = 0; i < DW; i++) if (d[i]) k = k ^ col_of(i);
    s = k ^ c;
    od = d;
    e = 2'd3;
    if (s == 0) e = 2'd0;
    else begin
      for (int i = 0; i < DW; i++) if (col_of(i) == s) begin od[i] = ~od[i]; e = 2'd1; end
      if (e == 2'd3 && $countones(s) == 1) e = 2'd2;
    end
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic gen(output logic [DW-1:0] d, output logic [PW-1:0] c);
    logic [DW+PW-1:0] cw;
    logic [DW-1:0] od;
    logic [1:0] e;
    logic [PW-1:0] s;
    int p1, p2, mode;
    d = $urandom;
    ref_dec(d, '0, od, e, s);
    cw = {s, d};
    mode = $urandom_range(0, 3);
    p1 = $urandom_range(0, DW + PW - 1);
    p2 = (p1 + $urandom_range(1, DW + PW - 1)) % (DW + PW);
    if (mode == 1) cw[$urandom_range(0, DW - 1)] ^= 1'b1;
    if (mode == 2) cw[DW + $urandom_range(0, PW - 1)] ^= 1'b1;
    if (mode == 3) begin cw[p1] ^= 1'b1; cw[p2] ^= 1'b1; end
    d = cw[DW-1:0];
    c = cw[DW+PW-1:DW];
  endtask
  task automatic clr_model();
    m_corr = 0; m_uncorr = 0; m_irq = 0; m_lv = 0; m_lt = 0; m_ls = 0;
  endtask
  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [PW-1:0] c, input logic [TW-1:0] t,
                     input bit rdy, input bit clr, output bit a);
    item_t it;
    bit ev, er;
    int due;
    in_valid = v; in_data = d; in_check = c; in_tag = t; out_ready = rdy; clr_cnt = clr;
    #1;
    due = 0;
    if (q.size() > 0) due = (q[0].a + 2 > last_pop + 1) ? q[0].a + 2 : last_pop + 1;
    ev = q.size() > 0 && cyc_n >= due;
    er = !(q.size() == 2 && !rdy);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    if (ev) begin
      chk("out_data", out_data, q[0].d);
      chk("out_err", out_err, q[0].e);
      chk("out_syn", out_syn, q[0].s);
      chk("out_tag", out_tag, q[0].t);
    end
    a = v && er;
    if (ev && rdy) begin
      it = q.pop_front();
      last_pop = cyc_n;
      if (!clr) begin
        if ((it.e == 2'd1 || it.e == 2'd2) && m_corr < CMAX) m_corr++;
        if (it.e == 2'd3) begin
          if (m_uncorr < CMAX) m_uncorr++;
          m_irq = 1;
          if (!m_lv) begin m_lv = 1; m_lt = it.t; m_ls = it.s; end
        end
      end
    end
    if (clr) clr_model();
    if (a) begin
      ref_dec(d, c, it.d, it.e, it.s);
      it.t = t;
      it.a = cyc_n;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    chk("cnt_corr", cnt_corr, m_corr);
    chk("cnt_uncorr", cnt_uncorr, m_uncorr);
    chk("irq_uncorr", irq_uncorr, m_irq);
`ifdef SECDED_ERR_LOG_EN
    chk("log_valid", log_valid, m_lv);
    chk("log_tag", log_tag, m_lt);
    chk("log_syn", log_syn, m_ls);
`endif
  endtask
  task automatic dir(input logic [DW-1:0] d, input logic [PW-1:0] c, input logic [TW-1:0] t,
                     input logic [DW-1:0] ed, input logic [1:0] ee, input logic [PW-1:0] es);
    bit a;
    cyc(1, d, c, t, 1, 0, a);
    cyc(0, '0, '0, '0, 1, 0, a);
    chk("dir_valid", out_valid, 1);
    chk("dir_data", out_data, ed);
    chk("dir_err", out_err, ee);
    chk("dir_syn", out_syn, es);
    chk("dir_tag", out_tag, t);
    cyc(0, '0, '0, '0, 1, 0, a);
  endtask
  initial begin
    logic [DW-1:0] d;
    logic [PW-1:0] c;
    int sent;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_syn", out_syn, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_cnt_corr", cnt_corr, 0);
    chk("rst_cnt_uncorr", cnt_uncorr, 0);
    chk("rst_irq", irq_uncorr, 0);
    @(posedge clk);
    #1;
    rst = 0;
    dir(32'h1, 7'h43, 4'h5, 32'h1, 2'b00, 7'h00);
    dir(32'h0, 7'h43, 4'h6, 32'h1, 2'b01, 7'h43);
    dir(32'h1, 7'h42, 4'h7, 32'h1, 2'b10, 7'h01);
    dir(32'h0, 7'h06, 4'h8, 32'h0, 2'b11, 7'h06);
    chk("plan_cnt_corr", cnt_corr, 2);
    chk("plan_cnt_uncorr", cnt_uncorr, 1);
    chk("plan_irq", irq_uncorr, 1);
`ifdef SECDED_ERR_LOG_EN
    chk("plan_log_syn", log_syn, 7'h06);
`endif
    sent = 0;
    gen(d, c);
    for (int k = 0; k < 40 && sent < 8; k++) begin
      cyc(1, d, c, 4'(sent), !(k >= 3 && k < 6), 0, acc);
      if (acc) begin sent++; gen(d, c); end
    end
    repeat (6) cyc(0, '0, '0, '0, 1, 0, acc);
    gen(d, c);
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 1), d, c, 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
      if (acc) gen(d, c);
    end
    repeat (6) cyc(0, '0, '0, '0, 1, 0, acc);
    repeat (20) cyc(1, 32'h0, 7'h43, 4'h1, 1, 0, acc);
    repeat (3) cyc(0, '0, '0, '0, 1, 0, acc);
    chk("sat_corr", cnt_corr, CMAX);
    cyc(1, 32'h0, 7'h06, 4'h2, 0, 0, acc);
    cyc(0, '0, '0, '0, 0, 0, acc);
    cyc(0, '0, '0, '0, 1, 1, acc);
    chk("clr_corr", cnt_corr, 0);
    chk("clr_uncorr", cnt_uncorr, 0);
    chk("clr_irq", irq_uncorr, 0);
    for (int k = 0; k < 3; k++) begin
      gen(d, c);
      cyc(1, d, c, 4'(k), 0, 0, acc);
    end
    rst = 1;
    #1;
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_ready", in_ready, 1);
    @(posedge clk);
    #1;
    cyc_n++;
    chk("rst_next_valid", out_valid, 0);
    rst = 0;
    q.delete();
    clr_model();
    chk("rst_next_corr", cnt_corr, 0);
    dir(32'h1, 7'h43, 4'h9, 32'h1, 2'b00, 7'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
